// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Definitions shared by the PWM timebase blocks: the counting-mode type and its
//   encodings. The top-level and the testbench import this package.
//   Ports: none (package).
//   Configuration macro used elsewhere in this slice: PWM_TB_PRESCALE_EN.
package pwm_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP      = 2'b00;
    localparam mode_t MODE_DOWN    = 2'b01;
    localparam mode_t MODE_UPDOWN  = 2'b10;
    localparam mode_t MODE_ONESHOT = 2'b11;

endpackage

// File: rtl/pwm_timebase_counter_if.sv
// pwm_timebase_counter_if
//   Bundles the control inputs and status outputs of the PWM timebase counter.
//   master modport: drives enable/mode/period/load/load_value (and prescale),
//                   observes counter_out/dir_down/wrap_pulse/top_pulse/done.
//   slave modport : the counter side, directions reversed.
//   Macro PWM_TB_PRESCALE_EN adds the prescale field and its PRESCALE_BITS parameter.
interface pwm_timebase_counter_if #(
    parameter int COUNTER_BITS = 8
`ifdef PWM_TB_PRESCALE_EN
    ,
    parameter int PRESCALE_BITS = 8
`endif
);
    import pwm_pkg::*;

    logic                    enable;
    mode_t                   mode;
    logic [COUNTER_BITS-1:0] period;
    logic                    load;
    logic [COUNTER_BITS-1:0] load_value;
`ifdef PWM_TB_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] prescale;
`endif
    logic [COUNTER_BITS-1:0] counter_out;
    logic                    dir_down;
    logic                    wrap_pulse;
    logic                    top_pulse;
    logic                    done;

    modport master (
        output enable, mode, period, load, load_value,
`ifdef PWM_TB_PRESCALE_EN
        output prescale,
`endif
        input  counter_out, dir_down, wrap_pulse, top_pulse, done
    );

    modport slave (
        input  enable, mode, period, load, load_value,
`ifdef PWM_TB_PRESCALE_EN
        input  prescale,
`endif
        output counter_out, dir_down, wrap_pulse, top_pulse, done
    );

endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
//   Clock divider for the timebase: tick is asserted on every (prescale+1)-th
//   clock while clear is low. clear forces the divider back to zero.
//   Ports: clk, reset_n (async active-low), clear, prescale[PRESCALE_BITS], tick.
//   Only instantiated when PWM_TB_PRESCALE_EN is defined.
module pwm_prescaler #(
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic                     tick
);

    localparam logic [PRESCALE_BITS-1:0] DIV_ONE = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] div;

    // >= rather than == so a prescale lowered below the running divider
    // still ticks immediately instead of running round the whole range.
    assign tick = !clear && (div >= prescale);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (clear || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_ONE;
        end
    end

endmodule

// File: rtl/pwm_timebase_counter.sv
// pwm_timebase_counter
//   Programmable PWM timebase: up-sawtooth, down-sawtooth, up/down triangle and
//   one-shot counting against a shadowed period, with registered boundary pulses.
//   Ports: clk, reset_n (async active-low), bus (pwm_timebase_counter_if.slave):
//     in : enable, mode, period, load, load_value, prescale (macro only)
//     out: counter_out, dir_down, wrap_pulse, top_pulse, done
//   Macro PWM_TB_PRESCALE_EN: steps come from pwm_prescaler instead of every
//   enabled clock.
module pwm_timebase_counter
    import pwm_pkg::*;
#(
    parameter int COUNTER_BITS  = 8,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pwm_timebase_counter_if.slave  bus
);

    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

    if (COUNTER_BITS < 1 || PRESCALE_BITS < 1) begin : g_bad_param
        $error("pwm_timebase_counter: COUNTER_BITS and PRESCALE_BITS must be >= 1");
    end

    logic [COUNTER_BITS-1:0] cnt, cnt_nxt;
    logic [COUNTER_BITS-1:0] period_s;
    mode_t                   mode_s;
    logic                    dir_q, dir_nxt;
    logic                    done_q, done_nxt;
    logic                    wrap_q, wrap_nxt;
    logic                    top_q, top_nxt;
    logic                    boundary;
    logic                    step;

`ifdef PWM_TB_PRESCALE_EN
    pwm_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (bus.load || !bus.enable),
        .prescale (bus.prescale),
        .tick     (step)
    );
`else
    assign step = bus.enable;
`endif

    // Next state assuming this clock is a step; the register block decides
    // whether load/enable override it.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir_q;
        done_nxt = done_q;
        wrap_nxt = 1'b0;
        top_nxt  = 1'b0;
        boundary = 1'b0;
        unique case (mode_s)
            MODE_UP: begin
                dir_nxt = 1'b0;
                if (cnt >= period_s) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                    top_nxt = (cnt_nxt == period_s);
                end
            end
            MODE_DOWN: begin
                dir_nxt = 1'b1;
                if (cnt == '0) begin
                    // Reload with the period being shadowed on this boundary.
                    cnt_nxt  = bus.period;
                    wrap_nxt = 1'b1;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            MODE_UPDOWN: begin
                if (!dir_q && cnt < period_s) begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt_nxt == period_s) begin
                        dir_nxt = 1'b1;
                        top_nxt = 1'b1;
                    end
                end else if (cnt <= CNT_ONE) begin
                    // Arrival at 0 from the falling half; also holds 0 when P=0.
                    cnt_nxt  = '0;
                    dir_nxt  = 1'b0;
                    wrap_nxt = 1'b1;
                    boundary = 1'b1;
                end else begin
                    // Falling half, or a count above P that must come back down.
                    cnt_nxt = cnt - CNT_ONE;
                    dir_nxt = 1'b1;
                end
            end
            MODE_ONESHOT: begin
                dir_nxt = 1'b0;
                if (!done_q) begin
                    if (cnt < period_s) begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (cnt_nxt == period_s) begin
                            done_nxt = 1'b1;
                            top_nxt  = 1'b1;
                        end
                    end else begin
                        cnt_nxt  = period_s;
                        done_nxt = 1'b1;
                        top_nxt  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            top_q    <= 1'b0;
            period_s <= '0;
            mode_s   <= MODE_UP;
        end else if (bus.load) begin
            cnt      <= bus.load_value;
            dir_q    <= (bus.mode == MODE_DOWN);
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            top_q    <= 1'b0;
            period_s <= bus.period;
            mode_s   <= bus.mode;
        end else if (!bus.enable) begin
            wrap_q   <= 1'b0;
            top_q    <= 1'b0;
            period_s <= bus.period;
            mode_s   <= bus.mode;
        end else if (step) begin
            cnt    <= cnt_nxt;
            dir_q  <= dir_nxt;
            done_q <= done_nxt;
            wrap_q <= wrap_nxt;
            top_q  <= top_nxt;
            if (boundary) begin
                period_s <= bus.period;
                mode_s   <= bus.mode;
            end
        end else begin
            wrap_q <= 1'b0;
            top_q  <= 1'b0;
        end
    end

    assign bus.counter_out = cnt;
    assign bus.dir_down    = dir_q;
    assign bus.wrap_pulse  = wrap_q;
    assign bus.top_pulse   = top_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_pwm_timebase_counter.sv
// tb_pwm_timebase_counter
//   Directed testbench for pwm_timebase_counter: reset values, all four modes,
//   period shadowing, load priority, enable hold, asynchronous reset and (with
//   PWM_TB_PRESCALE_EN) the prescaled step rate.
module tb_pwm_timebase_counter;
    import pwm_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    pwm_timebase_counter_if bus ();

    pwm_timebase_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int c, input int d,
                                input int w, input int t, input int dn);
        check({tag, ".cnt"},  bus.counter_out, c);
        check({tag, ".dir"},  32'(bus.dir_down), d);
        check({tag, ".wrap"}, 32'(bus.wrap_pulse), w);
        check({tag, ".top"},  32'(bus.top_pulse), t);
        check({tag, ".done"}, 32'(bus.done), dn);
    endtask

    // One clock, then sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input mode_t m, input int p, input int v);
        bus.load       = 1'b1;
        bus.mode       = m;
        bus.period     = 8'(p);
        bus.load_value = 8'(v);
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n        = 1'b0;
        bus.enable     = 1'b0;
        bus.mode       = MODE_UP;
        bus.period     = 8'd4;
        bus.load       = 1'b0;
        bus.load_value = 8'd0;
`ifdef PWM_TB_PRESCALE_EN
        bus.prescale   = '0;
`endif
        tick();
        tick();
        expect_state("reset", 0, 0, 0, 0, 0);

        // UP, P=4: shadows pick up period/mode while disabled
        reset_n = 1'b1;
        tick();
        bus.enable = 1'b1;
        begin
            int ec[6] = '{1, 2, 3, 4, 0, 1};
            int ew[6] = '{0, 0, 0, 0, 1, 0};
            int et[6] = '{0, 0, 0, 1, 0, 0};
            for (int i = 0; i < 6; i++) begin
                tick();
                expect_state($sformatf("up%0d", i), ec[i], 0, ew[i], et[i], 0);
            end
        end

        // load beyond P together with enable: load wins, then >= wraps to 0
        do_load(MODE_UP, 4, 9);
        expect_state("ld9", 9, 0, 0, 0, 0);
        tick();
        expect_state("ld9.wrap", 0, 0, 1, 0, 0);

        // UPDOWN, P=3
        do_load(MODE_UPDOWN, 3, 0);
        expect_state("ud.ld", 0, 0, 0, 0, 0);
        begin
            int ec[7] = '{1, 2, 3, 2, 1, 0, 1};
            int ed[7] = '{0, 0, 1, 1, 1, 0, 0};
            int ew[7] = '{0, 0, 0, 0, 0, 1, 0};
            int et[7] = '{0, 0, 1, 0, 0, 0, 0};
            for (int i = 0; i < 7; i++) begin
                tick();
                expect_state($sformatf("ud%0d", i), ec[i], ed[i], ew[i], et[i], 0);
            end
        end

        // DOWN, P=5, period changed to 2 at c=3
        do_load(MODE_DOWN, 5, 5);
        expect_state("dn.ld", 5, 1, 0, 0, 0);
        tick();
        expect_state("dn.4", 4, 1, 0, 0, 0);
        tick();
        expect_state("dn.3", 3, 1, 0, 0, 0);
        bus.period = 8'd2;
        begin
            int ec[7] = '{2, 1, 0, 2, 1, 0, 2};
            int ew[7] = '{0, 0, 0, 1, 0, 0, 1};
            for (int i = 0; i < 7; i++) begin
                tick();
                expect_state($sformatf("dn%0d", i), ec[i], 1, ew[i], 0, 0);
            end
        end

        // ONESHOT, P=3
        do_load(MODE_ONESHOT, 3, 0);
        expect_state("os.ld", 0, 0, 0, 0, 0);
        begin
            int ec[5] = '{1, 2, 3, 3, 3};
            int et[5] = '{0, 0, 1, 0, 0};
            int ed[5] = '{0, 0, 1, 1, 1};
            for (int i = 0; i < 5; i++) begin
                tick();
                expect_state($sformatf("os%0d", i), ec[i], 0, 0, et[i], ed[i]);
            end
        end
        do_load(MODE_ONESHOT, 3, 0);
        expect_state("os.reld", 0, 0, 0, 0, 0);
        tick();
        expect_state("os.restart", 1, 0, 0, 0, 0);

        // P=0 in UP: hold 0, wrap every step
        do_load(MODE_UP, 0, 0);
        tick();
        expect_state("p0.a", 0, 0, 1, 0, 0);
        tick();
        expect_state("p0.b", 0, 0, 1, 0, 0);

        // enable=0 holds the count and silences pulses
        do_load(MODE_UP, 4, 2);
        tick();
        expect_state("hold.pre", 3, 0, 0, 0, 0);
        bus.enable = 1'b0;
        tick();
        expect_state("hold.a", 3, 0, 0, 0, 0);
        tick();
        expect_state("hold.b", 3, 0, 0, 0, 0);
        bus.enable = 1'b1;
        tick();
        expect_state("hold.top", 4, 0, 0, 1, 0);
        tick();
        expect_state("hold.wrap", 0, 0, 1, 0, 0);

        // UP: period change mid-count applies only after the next wrap
        tick();
        bus.period = 8'd2;
        begin
            int ec[7] = '{2, 3, 4, 0, 1, 2, 0};
            int ew[7] = '{0, 0, 0, 1, 0, 0, 1};
            int et[7] = '{0, 0, 1, 0, 0, 1, 0};
            for (int i = 0; i < 7; i++) begin
                tick();
                expect_state($sformatf("sh%0d", i), ec[i], 0, ew[i], et[i], 0);
            end
        end

        // asynchronous reset at c=7 while counting down
        do_load(MODE_DOWN, 10, 8);
        tick();
        expect_state("ar.pre", 7, 1, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        expect_state("ar", 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;

`ifdef PWM_TB_PRESCALE_EN
        // prescale=2: one step every third enabled clock; load clears divider
        bus.prescale = 8'd2;
        do_load(MODE_UP, 10, 0);
        begin
            int ec[6] = '{0, 0, 1, 1, 1, 2};
            for (int i = 0; i < 6; i++) begin
                tick();
                check($sformatf("ps%0d", i), bus.counter_out, ec[i]);
            end
        end
        tick();
        check("ps.mid", bus.counter_out, 2);
        do_load(MODE_UP, 10, 5);
        check("ps.ld", bus.counter_out, 5);
        tick();
        check("ps.ld1", bus.counter_out, 5);
        tick();
        check("ps.ld2", bus.counter_out, 5);
        tick();
        check("ps.ld3", bus.counter_out, 6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
